fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that produces the instr_i/pc_i pair consumed by the decoder.
- Owns the architectural fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small instruction buffer and presents them to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered instructions and discarding stale in-flight responses.

Parameters:
XLEN, 32, data/address width; taken from riscv_pkg.
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
BUF_DEPTH, 2, instruction buffer entries; also the cap on in-flight plus buffered requests. Must be ≥1.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous reset, active-high.
imem_req_v_o  out  1  request valid.
imem_req_ready_i  in  1  memory accepts request.
imem_req_addr_o  out  XLEN  word-aligned fetch address.
imem_rsp_v_i  in  1  response valid; in order; latency ≥1 cycle; no backpressure.
imem_rsp_data_i  in  XLEN  instruction word.
redirect_v_i  in  1  redirect request from execute.
redirect_pc_i  in  XLEN  redirect target.
instr_v_o  out  1  instruction valid to decode.
instr_o  out  XLEN  instruction word (decoder instr_i).
pc_o  out  XLEN  PC of instr_o (decoder pc_i).
decode_ready_i  in  1  decoder consumes instr_o this cycle.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; rsp_pc = RESET_PC.
  - outstanding = 0; drop_cnt = 0; buffer empty.
  - imem_req_v_o = 0; instr_v_o = 0.
  - instr_o and pc_o read 0 (buffer storage is cleared).
  - The memory is reset together with this block, so no response arrives after reset that belongs to an earlier request.
- Request issue:
  - imem_req_v_o = !rst_i & !redirect_v_i & (outstanding + occupancy < BUF_DEPTH).
  - imem_req_addr_o = fetch_pc.
  - On imem_req_v_o & imem_req_ready_i: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Response handling:
  - On imem_rsp_v_i, outstanding -= 1.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_pc, imem_rsp_data_i} into the buffer and add 4 to rsp_pc.
  - The credit rule guarantees no push into a full buffer. Assert: push while full never occurs.
  - A simultaneous accepted request and received response leave outstanding unchanged.
- Decode output:
  - instr_v_o = buffer non-empty; {pc_o, instr_o} = head entry.
  - Pop on instr_v_o & decode_ready_i.
  - Push and pop in the same cycle are legal at any occupancy.
  - Minimum latency is one cycle: a response in cycle N gives instr_v_o in cycle N+1. There is no combinational path from imem_rsp_* to instr_*.
  - Outputs stay stable while instr_v_o & !decode_ready_i.
- Redirect (redirect_v_i = 1), highest priority after reset:
  - The buffer is flushed; any pop that cycle is ignored.
  - fetch_pc = rsp_pc = {redirect_pc_i[XLEN-1:2], 2'b00}; the low two bits are ignored.
  - drop_cnt = outstanding - (imem_rsp_v_i ? 1 : 0) + (existing drop_cnt already covered, since outstanding counts all in-flight requests). Any response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle; fetch resumes the next cycle from the new PC.
  - A redirect while drop_cnt > 0 simply recomputes drop_cnt from outstanding.
  - Back-to-back redirects: the last one wins.
- Counter widths:
  - outstanding and drop_cnt are $clog2(BUF_DEPTH+1) bits.
  - Assert: outstanding never underflows (no response when outstanding = 0).
- No state machine beyond the counters: the block is either fetching or stalled on credits, memory ready, or redirect.

Decomposition:
- riscv_pkg:
  - XLEN (existing).
  - INSTR_BYTES = 4.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_entry_t packed struct {pc, instr}.
- Sub-module fetch_buf: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - flush has priority over push and pop.
- Top level: PC registers, credit/drop counters, glue logic.

Test Plan:
- Reset, RESET_PC=0x100, memory always ready, latency 1, decode always ready → requests to 0x100, 0x104, 0x108…; instr_v_o from cycle 2 onward with pc_o 0x100, 0x104…, one instruction per cycle.
- decode_ready_i=0 for 5 cycles, BUF_DEPTH=2 → at most 2 requests in flight or buffered; imem_req_v_o drops; instr_o/pc_o held stable; no buffer overflow; order preserved on release.
- Memory latency 3, two requests outstanding, redirect_v_i with redirect_pc_i=0x2002 → both stale responses dropped; next request addr 0x2000; first instr_v_o has pc_o=0x2000.
- Redirect in the same cycle as a response and a decode pop → response discarded, buffer empty next cycle, imem_req_v_o=0 that cycle.
- imem_req_ready_i toggling 1,0,0,1 → imem_req_addr_o held during stall; PCs contiguous with no skips or duplicates.
- fetch_pc=0xFFFF_FFFC → next address wraps to 0x0000_0000.
- Assert rst_i mid-stream with a full buffer → next cycle instr_v_o=0, imem_req_v_o=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width and the fetch buffer entry format.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop.
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_i,
    input  fetch_entry_t                     push_data_i,
    input  logic                             pop_i,
    input  logic                             flush_i,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [$clog2(DEPTH + 1)-1:0]     count_o,
    output fetch_entry_t                     head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !flush_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential word requests, in-order response
// buffering toward decode, and redirect handling that drops stale in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_v_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_v_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_v_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_v_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            decode_ready_i
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] buf_count;
    logic [XLEN-1:0]  redirect_pc_aligned;
    logic             has_credit;
    logic             req_fire;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             unused_redirect_lo;

    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_redirect_lo  = ^redirect_pc_i[1:0];

    // Credits count both in-flight and buffered words so a response always has a free slot.
    assign has_credit      = (SUM_W'(outstanding_q) + SUM_W'(buf_count)) < SUM_W'(BUF_DEPTH);
    assign imem_req_v_o    = !rst_i && !redirect_v_i && has_credit;
    assign imem_req_addr_o = fetch_pc_q;
    assign req_fire        = imem_req_v_o && imem_req_ready_i;

    assign buf_push   = imem_rsp_v_i && (drop_q == '0) && !redirect_v_i;
    assign buf_pop    = instr_v_o && decode_ready_i && !redirect_v_i;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

    assign instr_v_o = !buf_empty;
    assign instr_o   = head_entry.instr;
    assign pc_o      = head_entry.pc;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .flush_i     (redirect_v_i),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count),
        .head_o      (head_entry)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_v_i);
        if (redirect_v_i) begin
            // Every request still in flight is stale, minus the one answered right now.
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            drop_d     = outstanding_q - CNT_W'(imem_rsp_v_i);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (imem_rsp_v_i) begin
                if (drop_q != '0) drop_d   = drop_q - CNT_W'(1);
                else              rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rsp_v_i && (outstanding_q == '0)))
                else $error("fetch_unit: response with no outstanding request");
            assert (!(buf_push && buf_full))
                else $error("fetch_unit: push into full instruction buffer");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_v_o;
    logic        imem_req_ready_i = 1'b1;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_v_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_v_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        decode_ready_i = 1'b1;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    logic [31:0] q_addr [$];
    int unsigned q_due [$];

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .RESET_PC  (32'h0000_0100),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_v_o     (imem_req_v_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_v_i     (imem_rsp_v_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_v_i     (redirect_v_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_v_o        (instr_v_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .decode_ready_i   (decode_ready_i)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: responses appear mem_lat cycles after the accepting edge, in order.
    always @(posedge clk_i) begin
        cyc = cyc + 1;
        #1;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_v_i    = 1'b1;
            imem_rsp_data_i = word_of(q_addr[0]);
            void'(q_due.pop_front());
            void'(q_addr.pop_front());
        end else begin
            imem_rsp_v_i    = 1'b0;
            imem_rsp_data_i = '0;
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            q_addr.delete();
            q_due.delete();
        end else if (imem_req_v_o && imem_req_ready_i) begin
            q_addr.push_back(imem_req_addr_o);
            q_due.push_back(cyc + mem_lat);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release, before its sampling edge.
    task automatic apply_reset();
        tick();
        rst_i = 1'b1; redirect_v_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready_i = 1'b1; decode_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL reset_req_v got=%0b want=0", imem_req_v_o); end
        total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL reset_instr_v got=%0b want=0", instr_v_o); end
        total++; if (pc_o !== 32'h0 || instr_o !== 32'h0) begin bad++; $display("FAIL reset_head got=%h/%h want=0/0", pc_o, instr_o); end
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (imem_req_v_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin bad++; $display("FAIL reset_first_req got=%0b/%h want=1/00000100", imem_req_v_o, imem_req_addr_o); end
        total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL reset_release_v got=%0b want=0", instr_v_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc, exp_req;
        int seen, issued, popped;
        exp_pc = 32'h100; exp_req = 32'h100; seen = 0; issued = 0; popped = 0;
        apply_reset();
        for (int k = 0; k < 40 && seen < 6; k++) begin
            if (k > 0) tick();
            @(negedge clk_i);
            if (k < 2) begin total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL stream_early_v k=%0d got=%0b want=0", k, instr_v_o); end end
            if (k == 2) begin total++; if (instr_v_o !== 1'b1) begin bad++; $display("FAIL stream_first_v got=%0b want=1", instr_v_o); end end
            total++; if (issued - popped > 2) begin bad++; $display("FAIL stream_credit got=%0d want<=2", issued - popped); end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL stream_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4; issued++;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL stream_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++; popped++;
            end
        end
        total++; if (seen < 6) begin bad++; $display("FAIL stream_timeout got=%0d want=6", seen); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc, exp_req;
        int seen, issued, popped;
        exp_pc = 32'h100; exp_req = 32'h100; seen = 0; issued = 0; popped = 0;
        apply_reset();
        for (int k = 0; k < 50 && seen < 8; k++) begin
            if (k > 0) begin tick(); decode_ready_i = (k < 4 || k >= 9); end
            @(negedge clk_i);
            total++; if (issued - popped > 2) begin bad++; $display("FAIL stall_credit got=%0d want<=2", issued - popped); end
            if (k >= 7 && k <= 8) begin
                total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL stall_req_v k=%0d got=%0b want=0", k, imem_req_v_o); end
                total++; if (instr_v_o !== 1'b1) begin bad++; $display("FAIL stall_instr_v k=%0d got=%0b want=1", k, instr_v_o); end
            end
            if (k >= 4 && k <= 8 && instr_v_o) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL stall_hold got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
            end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL stall_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4; issued++;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL stall_order got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++; popped++;
            end
        end
        decode_ready_i = 1'b1;
        total++; if (seen < 8) begin bad++; $display("FAIL stall_timeout got=%0d want=8", seen); end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] exp_pc, exp_req;
        int seen;
        exp_pc = 32'h2000; exp_req = 32'h100; seen = 0;
        mem_lat = 3;
        apply_reset();
        for (int k = 0; k < 40 && seen < 2; k++) begin
            if (k > 0) begin tick(); redirect_v_i = (k == 2); redirect_pc_i = 32'h0000_2002; end
            @(negedge clk_i);
            if (k == 2) begin
                exp_req = 32'h2000;
                total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL rdrop_redirect_req_v got=%0b want=0", imem_req_v_o); end
            end
            if (k == 3) begin total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL rdrop_credit_hold got=%0b want=0", imem_req_v_o); end end
            if (k == 4) begin total++; if (imem_req_v_o !== 1'b1) begin bad++; $display("FAIL rdrop_resume got=%0b want=1", imem_req_v_o); end end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL rdrop_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL rdrop_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++;
            end
        end
        redirect_v_i = 1'b0;
        mem_lat = 1;
        total++; if (seen < 2) begin bad++; $display("FAIL rdrop_timeout got=%0d want=2", seen); end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] exp_pc, exp_req;
        int seen;
        exp_pc = 32'h100; exp_req = 32'h100; seen = 0;
        apply_reset();
        for (int k = 0; k < 40 && seen < 3; k++) begin
            if (k > 0) begin tick(); redirect_v_i = (k == 2); redirect_pc_i = 32'h0000_3000; end
            @(negedge clk_i);
            if (k == 2) begin
                exp_req = 32'h3000;
                total++; if (instr_v_o !== 1'b1 || pc_o !== 32'h100) begin bad++; $display("FAIL collide_pre_head got=%0b/%h want=1/00000100", instr_v_o, pc_o); end
                total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL collide_req_v got=%0b want=0", imem_req_v_o); end
            end
            if (k == 3) begin
                total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL collide_flushed got=%0b want=0", instr_v_o); end
                total++; if (imem_req_v_o !== 1'b1) begin bad++; $display("FAIL collide_resume got=%0b want=1", imem_req_v_o); end
            end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL collide_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL collide_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++;
            end
            if (k == 2) exp_pc = 32'h3000;
        end
        redirect_v_i = 1'b0;
        total++; if (seen < 3) begin bad++; $display("FAIL collide_timeout got=%0d want=3", seen); end
    endtask

    task automatic test_ready_toggle();
        logic [31:0] exp_pc, exp_req;
        int seen;
        exp_pc = 32'h100; exp_req = 32'h100; seen = 0;
        apply_reset();
        for (int k = 0; k < 40 && seen < 4; k++) begin
            if (k > 0) begin tick(); imem_req_ready_i = !(k == 1 || k == 2); end
            @(negedge clk_i);
            if (k == 1 || k == 2) begin
                total++; if (imem_req_v_o !== 1'b1 || imem_req_addr_o !== 32'h104) begin bad++; $display("FAIL toggle_hold k=%0d got=%0b/%h want=1/00000104", k, imem_req_v_o, imem_req_addr_o); end
            end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL toggle_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL toggle_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++;
            end
        end
        imem_req_ready_i = 1'b1;
        total++; if (seen < 4) begin bad++; $display("FAIL toggle_timeout got=%0d want=4", seen); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc, exp_req;
        int seen;
        exp_pc = 32'hFFFF_FFFC; exp_req = 32'hFFFF_FFFC; seen = 0;
        apply_reset();
        for (int k = 0; k < 40 && seen < 3; k++) begin
            if (k > 0) tick();
            redirect_v_i = (k == 0); redirect_pc_i = 32'hFFFF_FFFC;
            @(negedge clk_i);
            if (k == 0) begin total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL wrap_redirect_req_v got=%0b want=0", imem_req_v_o); end end
            if (k == 2) begin total++; if (imem_req_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr_zero got=%h want=00000000", imem_req_addr_o); end end
            if (imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL wrap_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4;
            end
            if (instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL wrap_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++;
            end
        end
        redirect_v_i = 1'b0;
        total++; if (seen < 3) begin bad++; $display("FAIL wrap_timeout got=%0d want=3", seen); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp_pc, exp_req;
        int seen;
        exp_pc = 32'h100; exp_req = 32'h100; seen = 0;
        apply_reset();
        for (int k = 0; k < 50 && seen < 2; k++) begin
            if (k > 0) tick();
            decode_ready_i = (k >= 10);
            rst_i = (k == 7 || k == 8);
            @(negedge clk_i);
            if (k >= 3 && k <= 6) begin
                total++; if (instr_v_o !== 1'b1 || pc_o !== 32'h100) begin bad++; $display("FAIL midrst_hold k=%0d got=%0b/%h want=1/00000100", k, instr_v_o, pc_o); end
            end
            if (k == 5) begin total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL midrst_full_req_v got=%0b want=0", imem_req_v_o); end end
            if (k == 7) begin total++; if (imem_req_v_o !== 1'b0) begin bad++; $display("FAIL midrst_rst_req_v got=%0b want=0", imem_req_v_o); end end
            if (k == 8) begin
                total++; if (instr_v_o !== 1'b0 || imem_req_v_o !== 1'b0) begin bad++; $display("FAIL midrst_cleared got=%0b/%0b want=0/0", instr_v_o, imem_req_v_o); end
                total++; if (pc_o !== 32'h0 || instr_o !== 32'h0) begin bad++; $display("FAIL midrst_head got=%h/%h want=0/0", pc_o, instr_o); end
            end
            if (k == 9) begin
                total++; if (imem_req_v_o !== 1'b1 || instr_v_o !== 1'b0) begin bad++; $display("FAIL midrst_restart got=%0b/%0b want=1/0", imem_req_v_o, instr_v_o); end
            end
            if (k >= 9 && imem_req_v_o && imem_req_ready_i) begin
                total++; if (imem_req_addr_o !== exp_req) begin bad++; $display("FAIL midrst_addr got=%h want=%h", imem_req_addr_o, exp_req); end
                exp_req += 32'd4;
            end
            if (k >= 9 && instr_v_o && decode_ready_i) begin
                total++; if (pc_o !== exp_pc || instr_o !== word_of(exp_pc)) begin bad++; $display("FAIL midrst_instr got=%h/%h want=%h/%h", pc_o, instr_o, exp_pc, word_of(exp_pc)); end
                exp_pc += 32'd4; seen++;
            end
        end
        rst_i = 1'b0;
        decode_ready_i = 1'b1;
        total++; if (seen < 2) begin bad++; $display("FAIL midrst_timeout got=%0d want=2", seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_ready_toggle();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
